// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of four valid/ready byte streams into one, one bounded burst per grant.
// Define STREAM_RR_ARBITER_HEADER_EN to prefix each burst with a {HDR_TAG,2'b00,grant} source byte.
module stream_rr_arbiter #(
    parameter int unsigned BURST_LEN = 16,
    parameter logic [3:0]  HDR_TAG   = 4'hA
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [3:0]  enable_in,
    input  logic [31:0] reqData_in,
    input  logic [3:0]  reqValid_in,
    output logic [3:0]  reqReady_out,
    output logic [7:0]  outData_out,
    output logic        outValid_out,
    input  logic        outReady_in,
    output logic [1:0]  grant_out,
    output logic        busy_out
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

`ifdef STREAM_RR_ARBITER_HEADER_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BURST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BURST} state_t;
    localparam logic [3:0] hdr_tag_unused = HDR_TAG;
`endif

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] elig;
    logic       found;
    logic [1:0] pick;
    logic       g_ok;

    // First eligible index scanning upward from the pointer, wrapping mod 4.
    always_comb begin
        elig  = enable_in & reqValid_in;
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[ptr_q + 2'(k)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(k);
            end
        end
    end

    assign g_ok = enable_in[grant_q] & reqValid_in[grant_q];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        outData_out  = 8'h00;
        outValid_out = 1'b0;
        reqReady_out = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = 8'h00;
`ifdef STREAM_RR_ARBITER_HEADER_EN
                    state_d = S_HEADER;
`else
                    state_d = S_BURST;
`endif
                end
            end
`ifdef STREAM_RR_ARBITER_HEADER_EN
            S_HEADER: begin
                outData_out  = {HDR_TAG, 2'b00, grant_q};
                outValid_out = 1'b1;
                if (outReady_in) state_d = S_BURST;
            end
`endif
            S_BURST: begin
                outData_out           = reqData_in[{grant_q, 3'b000} +: 8];
                outValid_out          = g_ok;
                reqReady_out[grant_q] = outReady_in & enable_in[grant_q];
                // A dropped valid/enable closes the burst without a transfer.
                if (!g_ok) begin
                    state_d = S_IDLE;
                    ptr_d   = grant_q + 2'd1;
                end else if (outReady_in) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        ptr_d   = grant_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_out = grant_q;
    assign busy_out  = (state_q != S_IDLE);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: vector table, hand sequences, random vs. reference model.
// Expectations follow STREAM_RR_ARBITER_HEADER_EN the same way the design does.
module tb_stream_rr_arbiter;
    localparam int BL = 4;
`ifdef STREAM_RR_ARBITER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en = 4'h0, vld = 4'h0;
    logic [31:0] data = 32'h0;
    logic        ordy = 1'b0;
    logic [3:0]  rdy_o;
    logic [7:0]  od;
    logic        ov, busy;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_fail = 0;

    stream_rr_arbiter #(.BURST_LEN(BL), .HDR_TAG(4'hA)) dut (
        .clk_in(clk), .reset_n_in(rst_n), .enable_in(en), .reqData_in(data),
        .reqValid_in(vld), .reqReady_out(rdy_o), .outData_out(od),
        .outValid_out(ov), .outReady_in(ordy), .grant_out(grant), .busy_out(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {ov, od, rdy_o, busy, grant};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 4'h0; vld = 4'h0; data = 32'h0; ordy = 1'b0;
        #1 check("reset_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: phase 0 idle, 1 header, 2 burst; bytes sent counted as an integer.
    int m_phase, m_ptr, m_grant, m_sent;

    task automatic model_out(output logic [15:0] e);
        logic [3:0] r;
        logic       v;
        logic [7:0] d;
        r = 4'h0; v = 1'b0; d = 8'h00;
        if (m_phase == 1) begin
            v = 1'b1;
            d = 8'hA0 | 8'(m_grant);
        end else if (m_phase == 2) begin
            v = en[m_grant] & vld[m_grant];
            d = data[m_grant*8 +: 8];
            r[m_grant] = ordy & en[m_grant];
        end
        e = {v, d, r, (m_phase != 0), 2'(m_grant)};
    endtask

    task automatic model_step();
        bit f;
        f = 1'b0;
        if (m_phase == 0) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!f && en[i] && vld[i]) begin
                    f = 1'b1;
                    m_grant = i;
                end
            end
            if (f) begin
                m_sent  = 0;
                m_phase = HDR ? 1 : 2;
            end
        end else if (m_phase == 1) begin
            if (ordy) m_phase = 2;
        end else begin
            if (!(en[m_grant] && vld[m_grant])) begin
                m_phase = 0;
                m_ptr   = (m_grant + 1) % 4;
            end else if (ordy) begin
                m_sent++;
                if (m_sent == BL) begin
                    m_phase = 0;
                    m_ptr   = (m_grant + 1) % 4;
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [7:0]  b2;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] v, logic [7:0] b, logic ev, logic [7:0] ed,
                                logic [3:0] er, logic eb, logic [1:0] eg);
        vec_t r;
        r.vld = v;
        r.b2  = b;
        r.exp = {ev, ed, er, eb, eg};
        return r;
    endfunction

    initial begin
        int exp_g, nb, bytes;
        logic prev;
        bit hit;
        logic [15:0] e;

        #1 check("reset_at_t0", 32'(outs()), 32'h0);

        // Requester 2 alone with bytes 10..14, downstream always ready.
`ifdef STREAM_RR_ARBITER_HEADER_EN
        tbl.push_back(mk(4'h4, 8'h10, 0, 8'h00, 4'h0, 0, 2'd0));
        tbl.push_back(mk(4'h4, 8'h10, 1, 8'hA2, 4'h0, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h10, 1, 8'h10, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h11, 1, 8'h11, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h12, 1, 8'h12, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h13, 1, 8'h13, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h14, 0, 8'h00, 4'h0, 0, 2'd2));
        tbl.push_back(mk(4'h4, 8'h14, 1, 8'hA2, 4'h0, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h14, 1, 8'h14, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h0, 8'h00, 0, 8'h00, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h0, 8'h00, 0, 8'h00, 4'h0, 0, 2'd2));
`else
        tbl.push_back(mk(4'h4, 8'h10, 0, 8'h00, 4'h0, 0, 2'd0));
        tbl.push_back(mk(4'h4, 8'h10, 1, 8'h10, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h11, 1, 8'h11, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h12, 1, 8'h12, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h13, 1, 8'h13, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h4, 8'h14, 0, 8'h00, 4'h0, 0, 2'd2));
        tbl.push_back(mk(4'h4, 8'h14, 1, 8'h14, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h0, 8'h00, 0, 8'h00, 4'h4, 1, 2'd2));
        tbl.push_back(mk(4'h0, 8'h00, 0, 8'h00, 4'h0, 0, 2'd2));
`endif
        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            en = 4'hF; ordy = 1'b1; vld = tbl[i].vld; data = {8'h00, tbl[i].b2, 16'h0000};
            #1 check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Requester 0 masked off while valid.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            en = 4'b1110; vld = 4'hF; ordy = 1'b1; data = $urandom;
            #1 check("en_mask", {30'b0, rdy_o[0], busy & (grant == 2'd0)}, 32'h0);
        end

        // All four valid: grants rotate 0,1,2,3,0 with BL bytes each.
        do_reset();
        en = 4'hF; vld = 4'hF; ordy = 1'b1; data = 32'h33221100;
        exp_g = 0; nb = 0; bytes = 0; prev = 1'b0;
        for (int c = 0; c < 80 && nb < 5; c++) begin
            @(negedge clk);
            #1;
            if (busy && !prev) begin
                check("rr_grant", 32'(grant), 32'(exp_g));
                check("rr_first", 32'(od), HDR ? 32'(8'hA0 | 8'(exp_g)) : 32'(data[exp_g*8 +: 8]));
                nb++;
                exp_g = (exp_g + 1) % 4;
            end
            if (!busy && prev) begin
                check("rr_len", 32'(bytes), 32'(BL));
                bytes = 0;
            end
            if (ov && rdy_o != 4'h0) bytes++;
            prev = busy;
        end
        check("rr_bursts", 32'(nb), 32'd5);

        // Asynchronous reset in the middle of requester 2's burst.
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            #1 if (busy && grant == 2'd2) hit = 1'b1;
        end
        check("rst_wait", 32'(hit), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("post_rst_grant", {29'b0, busy, grant}, 32'h4);

        // Random traffic against the reference model.
        do_reset();
        m_phase = 0; m_ptr = 0; m_grant = 0; m_sent = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en = ($urandom % 8 == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < 4; i++) vld[i] = ($urandom % 5) != 0;
            ordy = ($urandom % 4) != 0;
            data = $urandom;
            #1;
            model_out(e);
            check("random", 32'(outs()), 32'(e));
            @(posedge clk);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
